// File: rtl/petra_link.sv
// petra_link: LightIO shared-line serial transceiver with TX/RX FIFOs and arbiter request/grant.
// Optional feature: define PETRA_PARITY_EN to insert/check an even-parity bit before the stop bit.
//
// TX state | meaning                     RX state | meaning
// IDLE     | waiting for TX FIFO data    IDLE     | waiting for synchronised 0->1 edge
// REQ      | bus_request up, await grant START    | confirm start bit at midpoint
// START    | drive start bit (1)         DATA     | sample data bits, MSB first
// DATA     | drive data bits, MSB first  PAR      | sample parity bit (parity build)
// PAR      | drive parity (parity build) STOP     | sample stop bit, write RX FIFO
// STOP     | drive stop bit (0)
// DONE     | pop TX FIFO, pulse irq_tx

module petra_link #(
   parameter int MSG_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BIT_TICKS  = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 send_message,
   input  logic [MSG_WIDTH-1:0] data_in,
   input  logic                 read_message,
   output logic [MSG_WIDTH-1:0] data_out,
   output logic                 rx_valid,
   output logic                 tx_full,
   output logic                 rx_overflow,
   output logic                 irq_tx,
   output logic                 irq_rx,
   output logic                 bus_request,
   input  logic                 bus_grant,
   output logic                 signal_out,
   input  logic                 signal_in,
   output logic                 led
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(BIT_TICKS);
   localparam int BW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(BIT_TICKS / 2);
   localparam logic [BW-1:0] BIT_TOP   = BW'(MSG_WIDTH - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_REQ, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_DONE} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   tx_state_t            tx_state;
   logic [TW-1:0]        tx_tick;
   logic [BW-1:0]        tx_bit;
   logic [MSG_WIDTH-1:0] tx_mem [FIFO_DEPTH];
   logic [PW-1:0]        tx_wr, tx_rd;
   logic [CW-1:0]        tx_count;
   logic                 tx_push, tx_pop;
   logic [MSG_WIDTH-1:0] tx_head;

   assign tx_full = (tx_count == CNT_FULL);
   assign tx_push = send_message && !tx_full;
   assign tx_pop  = (tx_state == TX_DONE);
   assign tx_head = tx_mem[tx_rd];

   always_ff @(posedge clock) begin
      if (tx_push) tx_mem[tx_wr] <= data_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_count <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + PW'(1);
         if (tx_pop)  tx_rd <= tx_rd + PW'(1);
         if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
         else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state    <= TX_IDLE;
         tx_tick     <= '0;
         tx_bit      <= '0;
         bus_request <= 1'b0;
         signal_out  <= 1'b0;
         led         <= 1'b0;
         irq_tx      <= 1'b0;
      end else begin
         irq_tx <= 1'b0;
         case (tx_state)
            TX_IDLE: if (tx_count != '0) begin
               tx_state    <= TX_REQ;
               bus_request <= 1'b1;
            end
            TX_REQ: if (bus_grant) begin
               tx_state   <= TX_START;
               tx_tick    <= '0;
               signal_out <= 1'b1;
               led        <= 1'b1;
            end
            TX_START: if (tx_tick == TICK_LAST) begin
               tx_tick    <= '0;
               tx_bit     <= BIT_TOP;
               signal_out <= tx_head[MSG_WIDTH-1];
               tx_state   <= TX_DATA;
            end else tx_tick <= tx_tick + TW'(1);
            TX_DATA: if (tx_tick == TICK_LAST) begin
               tx_tick <= '0;
               if (tx_bit == '0) begin
`ifdef PETRA_PARITY_EN
                  tx_state   <= TX_PAR;
                  signal_out <= ^tx_head;
`else
                  tx_state   <= TX_STOP;
                  signal_out <= 1'b0;
`endif
               end else begin
                  tx_bit     <= tx_bit - BW'(1);
                  signal_out <= tx_head[tx_bit - BW'(1)];
               end
            end else tx_tick <= tx_tick + TW'(1);
            TX_PAR: if (tx_tick == TICK_LAST) begin
               tx_tick    <= '0;
               tx_state   <= TX_STOP;
               signal_out <= 1'b0;
            end else tx_tick <= tx_tick + TW'(1);
            TX_STOP: if (tx_tick == TICK_LAST) begin
               tx_tick     <= '0;
               tx_state    <= TX_DONE;
               led         <= 1'b0;
               bus_request <= 1'b0;
               irq_tx      <= 1'b1;
            end else tx_tick <= tx_tick + TW'(1);
            TX_DONE: tx_state <= TX_IDLE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Receiver: line is asynchronous, so only sync_2 (and its delayed copy) feed the FSM.
   logic sync_1, sync_2, sync_prev;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_1    <= signal_in;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   rx_state_t            rx_state;
   logic [TW-1:0]        rx_tick;
   logic [BW-1:0]        rx_bit;
   logic [MSG_WIDTH-1:0] rx_shift;
   logic                 rx_par_ok;
   logic [MSG_WIDTH-1:0] rx_mem [FIFO_DEPTH];
   logic [PW-1:0]        rx_wr, rx_rd;
   logic [CW-1:0]        rx_count;
   logic                 rx_full, rx_push, rx_pop, rx_frame_ok;

`ifndef PETRA_PARITY_EN
   assign rx_par_ok = 1'b1;
`endif

   assign rx_full     = (rx_count == CNT_FULL);
   assign rx_frame_ok = (rx_state == RX_STOP) && (rx_tick == TICK_MID) && !sync_2 && rx_par_ok;
   assign rx_push     = rx_frame_ok && !rx_full;
   assign rx_pop      = read_message && rx_valid;
   assign rx_valid    = (rx_count != '0);
   assign data_out    = rx_valid ? rx_mem[rx_rd] : '0;

   always_ff @(posedge clock) begin
      if (rx_push) rx_mem[rx_wr] <= rx_shift;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_count <= '0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + PW'(1);
         if (rx_pop)  rx_rd <= rx_rd + PW'(1);
         if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
         else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state    <= RX_IDLE;
         rx_tick     <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rx_overflow <= 1'b0;
         irq_rx      <= 1'b0;
`ifdef PETRA_PARITY_EN
         rx_par_ok   <= 1'b1;
`endif
      end else begin
         irq_rx <= 1'b0;
         case (rx_state)
            // The edge cycle is tick 0 of the start bit.
            RX_IDLE: if (sync_2 && !sync_prev) begin
               rx_state <= RX_START;
               rx_tick  <= TW'(1);
            end
            RX_START: if (rx_tick == TICK_MID && !sync_2) begin
               rx_state <= RX_IDLE;
               rx_tick  <= '0;
            end else if (rx_tick == TICK_LAST) begin
               rx_tick  <= '0;
               rx_bit   <= BIT_TOP;
               rx_state <= RX_DATA;
            end else rx_tick <= rx_tick + TW'(1);
            RX_DATA: begin
               if (rx_tick == TICK_MID) rx_shift <= {rx_shift[MSG_WIDTH-2:0], sync_2};
               if (rx_tick == TICK_LAST) begin
                  rx_tick <= '0;
                  if (rx_bit == '0) begin
`ifdef PETRA_PARITY_EN
                     rx_state <= RX_PAR;
`else
                     rx_state <= RX_STOP;
`endif
                  end else rx_bit <= rx_bit - BW'(1);
               end else rx_tick <= rx_tick + TW'(1);
            end
            RX_PAR: begin
`ifdef PETRA_PARITY_EN
               if (rx_tick == TICK_MID) rx_par_ok <= (sync_2 == ^rx_shift);
`endif
               if (rx_tick == TICK_LAST) begin
                  rx_tick  <= '0;
                  rx_state <= RX_STOP;
               end else rx_tick <= rx_tick + TW'(1);
            end
            RX_STOP: if (rx_tick == TICK_MID) begin
               rx_state <= RX_IDLE;
               rx_tick  <= '0;
               if (rx_frame_ok) begin
                  if (rx_full) rx_overflow <= 1'b1;
                  else         irq_rx      <= 1'b1;
               end
            end else rx_tick <= rx_tick + TW'(1);
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule
